// File: rtl/maze_pkg.sv
// maze_pkg: shared constants, state and error encodings for the maze transmit/check block
package maze_pkg;
  localparam int N = 15;
  localparam logic [3:0] START = 4'd1;
  localparam logic [3:0] GOAL = 4'd13;
  localparam int TIMEOUT = 1000;
  typedef enum logic [2:0] {IDLE, SEND, WAIT, PATH, REPORT} state_t;
  typedef enum logic [2:0] {
    E_NONE    = 3'd0,
    E_START   = 3'd1,
    E_ADJ     = 3'd2,
    E_WALL    = 3'd3,
    E_GOAL    = 3'd4,
    E_TIMEOUT = 3'd5,
    E_VERDICT = 3'd6,
    E_BOTH    = 3'd7
  } err_t;
endpackage

// File: rtl/maze_step_check.sv
// maze_step_check: legality of one solver coordinate plus the goal test on the last one
module maze_step_check
  import maze_pkg::*;
(
  input  logic       first,
  input  logic [3:0] cur_x,
  input  logic [3:0] cur_y,
  input  logic [3:0] prev_x,
  input  logic [3:0] prev_y,
  input  logic       wall,
  output err_t       step_err,
  output logic       at_goal
);
  logic [3:0] dx, dy;
  logic adj;
  always_comb begin
    dx = cur_x > prev_x ? cur_x - prev_x : prev_x - cur_x;
    dy = cur_y > prev_y ? cur_y - prev_y : prev_y - cur_y;
    adj = (dx == 4'd1 && dy == 4'd0) || (dx == 4'd0 && dy == 4'd1);
    step_err = first ? ((cur_x == START && cur_y == START) ? (wall ? E_WALL : E_NONE) : E_START)
             : !adj ? E_ADJ : wall ? E_WALL : E_NONE;
    at_goal = prev_x == GOAL && prev_y == GOAL;
  end
endmodule

// File: rtl/maze_tx_check.sv
// maze_tx_check: serialises a stored 15x15 maze to a solver and audits its reply
module maze_tx_check
  import maze_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        row_wr,
  input  logic [3:0]  row_addr,
  input  logic [14:0] row_data,
  input  logic        start,
  input  logic        expect_solvable,
  output logic        maze,
  output logic        in_valid,
  input  logic        out_valid,
  input  logic        maze_not_valid,
  input  logic [3:0]  out_x,
  input  logic [3:0]  out_y,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [2:0]  err_code,
  output logic [7:0]  step_cnt
);
  logic [N-1:0] mem [N];
  state_t state;
  err_t err_q, step_err, cand, final_err;
  logic [3:0] r, c, nr, nc, px, py;
  logic [9:0] wait_cnt;
  logic exp_s, first_bit, wall, at_goal, resp, both, verdict, end_path, timeout, go_report;

  assign err_code = err_q;

  always_ff @(posedge clk)
    if (state == IDLE && row_wr && row_addr < 4'(N)) mem[row_addr] <= row_data;

  maze_step_check u_step (
    .first    (state == WAIT),
    .cur_x    (out_x),
    .cur_y    (out_y),
    .prev_x   (px),
    .prev_y   (py),
    .wall     (wall),
    .step_err (step_err),
    .at_goal  (at_goal)
  );

  // a write landing on the start edge must already be visible in the first bit
  always_comb begin
    first_bit = (row_wr && row_addr == 4'd0) ? row_data[0] : mem[0][0];
    nc = c == 4'(N - 1) ? 4'd0 : c + 4'd1;
    nr = c == 4'(N - 1) ? r + 4'd1 : r;
    wall = (out_x >= 4'(N) || out_y >= 4'(N)) ? 1'b1 : mem[out_x][out_y];
    resp = state == WAIT || state == PATH;
    both = resp && out_valid && maze_not_valid;
    verdict = state == WAIT && maze_not_valid;
    end_path = state == PATH && !out_valid;
    timeout = state == WAIT && !out_valid && !maze_not_valid && wait_cnt == 10'(TIMEOUT - 1);
    cand = both ? E_BOTH
         : verdict ? (exp_s ? E_VERDICT : E_NONE)
         : (resp && out_valid) ? step_err
         : end_path ? (!at_goal ? E_GOAL : !exp_s ? E_VERDICT : E_NONE)
         : timeout ? E_TIMEOUT : E_NONE;
    final_err = err_q != E_NONE ? err_q : cand;
    go_report = both || verdict || end_path || timeout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      err_q <= E_NONE;
      step_cnt <= 8'd0;
      maze <= 1'b0;
      in_valid <= 1'b0;
      r <= 4'd0;
      c <= 4'd0;
      px <= 4'd0;
      py <= 4'd0;
      wait_cnt <= 10'd0;
      exp_s <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE:
          if (start) begin
            state <= SEND;
            busy <= 1'b1;
            in_valid <= 1'b1;
            maze <= first_bit;
            r <= 4'd0;
            c <= 4'd0;
            exp_s <= expect_solvable;
            pass <= 1'b0;
            err_q <= E_NONE;
            step_cnt <= 8'd0;
            wait_cnt <= 10'd0;
          end
        SEND:
          if (r == 4'(N - 1) && c == 4'(N - 1)) begin
            state <= WAIT;
            in_valid <= 1'b0;
            maze <= 1'b0;
          end else begin
            r <= nr;
            c <= nc;
            maze <= mem[nr][nc];
          end
        WAIT, PATH: begin
          err_q <= final_err;
          if (go_report) begin
            state <= REPORT;
            busy <= 1'b0;
            done <= 1'b1;
            pass <= final_err == E_NONE;
          end else if (out_valid) begin
            state <= PATH;
            px <= out_x;
            py <= out_y;
            step_cnt <= step_cnt + 8'(step_cnt != 8'hFF);
          end else
            wait_cnt <= wait_cnt + 10'd1;
        end
        REPORT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
